// File: rtl/bn2d_affine_stream_pkg.sv
// Shared constants and fixed-point helpers for the per-channel batch-norm affine stream.
package bn2d_affine_stream_pkg;

   localparam int DATA_W_DEF     = 16;
   localparam int FRAC_W_DEF     = 8;
   localparam int NUM_CH_DEF     = 8;
   localparam int PIX_PER_CH_DEF = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Half an LSB of the output Q format; zero when there are no fractional bits to round away.
   function automatic longint round_const(input int frac);
      if (frac > 0) begin
         return longint'(1) <<< (frac - 1);
      end
      return 0;
   endfunction

   function automatic longint sat_signed(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/bn2d_affine_stream_if.sv
// Streaming input/output handshake bundle of the batch-norm affine stage.
interface bn2d_affine_stream_if #(
   parameter int DATA_W = 16,
   parameter int CH_W   = 3
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic [CH_W-1:0]          out_ch;
   logic                     out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch, out_last
   );
endinterface

// File: rtl/bn2d_affine_stream_core.sv
// Two-stage affine datapath: S1 multiplies, S2 adds bias, rounds, shifts, saturates and applies ReLU.
module bn2d_affine_stream_core
   import bn2d_affine_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int CH_W   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_fire,
   input  logic signed [DATA_W-1:0] in_x,
   input  logic signed [DATA_W-1:0] in_w,
   input  logic signed [DATA_W-1:0] in_b,
   input  logic                     in_relu,
   input  logic [CH_W-1:0]          in_ch,
   input  logic                     in_last,
   input  logic                     advance,
   output logic                     s1_valid,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_last
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = 2 * DATA_W + 2;
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(FRAC_W));

   logic signed [PROD_W-1:0] s1_prod;
   logic signed [DATA_W-1:0] s1_bias;
   logic                     s1_relu;
   logic [CH_W-1:0]          s1_ch;
   logic                     s1_last;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [DATA_W-1:0] y;

   // S1 refills whenever it is empty or its content moves into S2 this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_prod  <= '0;
         s1_bias  <= '0;
         s1_relu  <= 1'b0;
         s1_ch    <= '0;
         s1_last  <= 1'b0;
      end else if (!s1_valid || advance) begin
         s1_valid <= in_fire;
         if (in_fire) begin
            s1_prod <= PROD_W'(in_x) * PROD_W'(in_w);
            s1_bias <= in_b;
            s1_relu <= in_relu;
            s1_ch   <= in_ch;
            s1_last <= in_last;
         end
      end
   end

   // Arithmetic shift of the rounded sum gives round-half-toward-plus-infinity.
   always_comb begin
      acc     = ACC_W'(s1_prod) + (ACC_W'(s1_bias) <<< FRAC_W) + RND;
      shifted = acc >>> FRAC_W;
      y       = DATA_W'(sat_signed(64'(shifted), DATA_W));
      if (s1_relu && y[DATA_W-1]) begin
         y = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= y;
            out_ch   <= s1_ch;
            out_last <= s1_last;
         end
      end
   end

endmodule

// File: rtl/bn2d_affine_stream.sv
// Per-channel batch-norm affine stream: weight/bias register file, frame sequencer and handshake around the core.
module bn2d_affine_stream
   import bn2d_affine_stream_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FRAC_W     = FRAC_W_DEF,
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int PIX_PER_CH = PIX_PER_CH_DEF,
   parameter int CH_W       = idx_width(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic signed [DATA_W-1:0] cfg_weight,
   input  logic signed [DATA_W-1:0] cfg_bias,
   input  logic                     relu_en,
   bn2d_affine_stream_if.slave      strm
);

   localparam int PIX_W = idx_width(PIX_PER_CH);

   logic signed [DATA_W-1:0] w_rf [NUM_CH];
   logic signed [DATA_W-1:0] b_rf [NUM_CH];
   logic [CH_W-1:0]          ch_cnt;
   logic [PIX_W-1:0]         pix_cnt;
   logic                     s1_valid;
   logic                     advance;
   logic                     in_fire;
   logic                     pix_wrap;
   logic                     ch_wrap;

   assign advance       = !strm.out_valid || strm.out_ready;
   assign strm.in_ready = !s1_valid || advance;
   assign in_fire       = strm.in_valid && strm.in_ready;
   assign pix_wrap      = (pix_cnt == PIX_W'(PIX_PER_CH - 1));
   assign ch_wrap       = (ch_cnt == CH_W'(NUM_CH - 1));

   // Registered file, so an accept in the same cycle as a write reads the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            w_rf[i] <= '0;
            b_rf[i] <= '0;
         end
      end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
         w_rf[cfg_ch] <= cfg_weight;
         b_rf[cfg_ch] <= cfg_bias;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt <= '0;
         ch_cnt  <= '0;
      end else if (in_fire) begin
         if (pix_wrap) begin
            pix_cnt <= '0;
            ch_cnt  <= ch_wrap ? '0 : ch_cnt + 1'b1;
         end else begin
            pix_cnt <= pix_cnt + 1'b1;
         end
      end
   end

   bn2d_affine_stream_core #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .CH_W   (CH_W)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .in_fire   (in_fire),
      .in_x      (strm.in_data),
      .in_w      (w_rf[ch_cnt]),
      .in_b      (b_rf[ch_cnt]),
      .in_relu   (relu_en),
      .in_ch     (ch_cnt),
      .in_last   (pix_wrap && ch_wrap),
      .advance   (advance),
      .s1_valid  (s1_valid),
      .out_valid (strm.out_valid),
      .out_data  (strm.out_data),
      .out_ch    (strm.out_ch),
      .out_last  (strm.out_last)
   );

endmodule
